// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: round-robin sharing of one 8-bit ripple-carry adder between two requesters.
// Define STATS_EN to add the per-requester completed-transaction counters cnt0/cnt1.

module adder_share_rca #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   logic [WIDTH:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < WIDTH; i++) begin : g_fa
      assign sum[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign cout = c[WIDTH];

endmodule

module adder_share_arbiter #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             ack0,
   output logic             ack1,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
`ifdef STATS_EN
   ,
   output logic [CNT_W-1:0] cnt0,
   output logic [CNT_W-1:0] cnt1
`endif
);

   if (WIDTH != 8) begin : g_width_check
      $error("adder_share_arbiter: WIDTH must be 8 to match the shared adder");
   end

   if (CNT_W < 1) begin : g_cnt_check
      $error("adder_share_arbiter: CNT_W must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      RESP
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             ptr;
   logic             gnt;
   logic             gnt_nxt;
   logic             do_grant;
   logic [WIDTH-1:0] opa;
   logic [WIDTH-1:0] opb;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;

   adder_share_rca #(
      .WIDTH (WIDTH)
   ) u_adder (
      .a    (opa),
      .b    (opb),
      .cin  (1'b0),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ptr selects the winner only on contention; a lone request always wins
   always_comb begin
      state_nxt = state;
      do_grant  = 1'b0;
      gnt_nxt   = gnt;
      unique case (state)
         IDLE: begin
            if (req0 || req1) begin
               do_grant  = 1'b1;
               gnt_nxt   = (req0 && req1) ? ptr : req1;
               state_nxt = CALC;
            end
         end
         CALC:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opa  <= '0;
         opb  <= '0;
         gnt  <= 1'b0;
         ptr  <= 1'b0;
         sum  <= '0;
         cout <= 1'b0;
         ack0 <= 1'b0;
         ack1 <= 1'b0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         if (do_grant) begin
            opa <= gnt_nxt ? a1 : a0;
            opb <= gnt_nxt ? b1 : b0;
            gnt <= gnt_nxt;
         end
         if (state == CALC) begin
            sum  <= add_sum;
            cout <= add_cout;
         end
         if (state == RESP) begin
            ack0 <= ~gnt;
            ack1 <= gnt;
            ptr  <= ~gnt;
         end
      end
   end

   assign busy = (state == CALC) || (state == RESP);

`ifdef STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         if (ack0) cnt0 <= cnt0 + 1'b1;
         if (ack1) cnt1 <= cnt1 + 1'b1;
      end
   end
`endif

endmodule
